// File: rtl/prach_pkg.sv
// prach_pkg: default widths and the packed per-channel control record.
package prach_pkg;
    localparam int DEF_NUM_CC = 3;
    localparam int DEF_NUM_ANT = 8;
    localparam int DEF_FCW_W = 17;
    localparam int DEF_TOFS_W = 20;
    localparam int DEF_NSYM_W = 4;
    typedef struct packed {
        logic [DEF_FCW_W-1:0] fcw;
        logic [DEF_TOFS_W-1:0] tofs;
        logic [DEF_NSYM_W-1:0] nsym;
    } prach_ctrl_t;
endpackage

// File: rtl/prach_ctrl_entry.sv
// prach_ctrl_entry: one channel's shadow/active register pair with pending flag.
module prach_ctrl_entry
    import prach_pkg::*;
#(
    parameter int FCW_W = DEF_FCW_W,
    parameter int TOFS_W = DEF_TOFS_W,
    parameter int NSYM_W = DEF_NSYM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              sync,
    input  logic [FCW_W-1:0]  wr_fcw,
    input  logic [TOFS_W-1:0] wr_tofs,
    input  logic [NSYM_W-1:0] wr_nsym,
    output logic [FCW_W-1:0]  act_fcw,
    output logic [TOFS_W-1:0] act_tofs,
    output logic [NSYM_W-1:0] act_nsym,
    output logic              pend
);
    logic [FCW_W-1:0]  sh_fcw;
    logic [TOFS_W-1:0] sh_tofs;
    logic [NSYM_W-1:0] sh_nsym;

    // Commit reads the old shadow, so a write landing with sync stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_fcw <= '0;
            sh_tofs <= '0;
            sh_nsym <= '0;
            act_fcw <= '0;
            act_tofs <= '0;
            act_nsym <= '0;
            pend <= 1'b0;
        end else begin
            if (sync && pend) begin
                act_fcw <= sh_fcw;
                act_tofs <= sh_tofs;
                act_nsym <= sh_nsym;
            end
            if (wr) begin
                sh_fcw <= wr_fcw;
                sh_tofs <= wr_tofs;
                sh_nsym <= wr_nsym;
            end
            pend <= wr | (pend & ~sync);
        end
    end
endmodule

// File: rtl/prach_ctrl_bank.sv
// prach_ctrl_bank: per-channel PRACH control shadow/active bank with slot commit and random read.
// Optional overwrite detection is built only when PRACH_CTRL_BANK_OVF_EN is defined.
module prach_ctrl_bank
    import prach_pkg::*;
#(
    parameter int NUM_CC = DEF_NUM_CC,
    parameter int NUM_ANT = DEF_NUM_ANT,
    parameter int FCW_W = DEF_FCW_W,
    parameter int TOFS_W = DEF_TOFS_W,
    parameter int NSYM_W = DEF_NSYM_W,
    localparam int N = NUM_CC * NUM_ANT,
    localparam int IDX_W = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        c_valid,
    input  logic [FCW_W-1:0]    c_frequency_offset,
    input  logic [TOFS_W-1:0]   c_time_offset,
    input  logic [NSYM_W-1:0]   c_num_symbol,
    input  logic                sync_in,
    output logic [N*FCW_W-1:0]  ctrl_fcw,
    output logic [N-1:0]        pend,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_chn,
    output logic                rd_vld,
    output logic                rd_err,
    output logic [FCW_W-1:0]    rd_fcw,
    output logic [TOFS_W-1:0]   rd_tofs,
    output logic [NSYM_W-1:0]   rd_nsym,
    output logic [15:0]         commit_cnt,
    output logic [N-1:0]        ovf,
    input  logic                ovf_clr
);
    localparam logic [IDX_W:0] N_V = N[IDX_W:0];

    logic [FCW_W-1:0]  act_fcw [N];
    logic [TOFS_W-1:0] act_tofs [N];
    logic [NSYM_W-1:0] act_nsym [N];
    logic              rd_hit;

    for (genvar g = 0; g < N; g++) begin : g_ch
        prach_ctrl_entry #(
            .FCW_W(FCW_W),
            .TOFS_W(TOFS_W),
            .NSYM_W(NSYM_W)
        ) u_entry (
            .clk(clk),
            .rst(rst),
            .wr(c_valid[g]),
            .sync(sync_in),
            .wr_fcw(c_frequency_offset),
            .wr_tofs(c_time_offset),
            .wr_nsym(c_num_symbol),
            .act_fcw(act_fcw[g]),
            .act_tofs(act_tofs[g]),
            .act_nsym(act_nsym[g]),
            .pend(pend[g])
        );
        assign ctrl_fcw[g*FCW_W +: FCW_W] = act_fcw[g];
    end

    assign rd_hit = {1'b0, rd_chn} < N_V;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld <= 1'b0;
            rd_err <= 1'b0;
            rd_fcw <= '0;
            rd_tofs <= '0;
            rd_nsym <= '0;
            commit_cnt <= '0;
        end else begin
            rd_vld <= rd_en;
            rd_err <= rd_en & ~rd_hit;
            if (rd_en) begin
                rd_fcw <= rd_hit ? act_fcw[rd_chn] : '0;
                rd_tofs <= rd_hit ? act_tofs[rd_chn] : '0;
                rd_nsym <= rd_hit ? act_nsym[rd_chn] : '0;
            end
            if (sync_in) commit_cnt <= commit_cnt + 16'd1;
        end
    end

`ifdef PRACH_CTRL_BANK_OVF_EN
    // A fresh overwrite outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf <= '0;
        else ovf <= (c_valid & pend & {N{~sync_in}}) | (ovf & {N{~ovf_clr}});
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf = '0;
`endif
endmodule

// File: doc/prach_ctrl_bank.md
PRACH_CTRL_BANK -- requirements
Module: prach_ctrl_bank

Interface
REQ-001 The block SHALL have parameter NUM_CC, default 3, number of component carriers.
REQ-002 The block SHALL have parameter NUM_ANT, default 8, number of antennas per CC.
REQ-003 The block SHALL have parameter FCW_W, default 17, frequency control word width.
REQ-004 The block SHALL have parameter TOFS_W, default 20, time offset width.
REQ-005 The block SHALL have parameter NSYM_W, default 4, number-of-symbols width.
REQ-006 Derived: N = NUM_CC*NUM_ANT, channel index i = cc*NUM_ANT + ant, IDX_W = $clog2(N).
REQ-007 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-008 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 The block SHALL have port c_valid, input, N, per-channel C-plane write strobe.
REQ-010 The block SHALL have port c_frequency_offset, input, FCW_W, write data FCW.
REQ-011 The block SHALL have port c_time_offset, input, TOFS_W, write data time offset.
REQ-012 The block SHALL have port c_num_symbol, input, NSYM_W, write data symbol count.
REQ-013 The block SHALL have port sync_in, input, 1, commit strobe at slot boundary.
REQ-014 The block SHALL have port ctrl_fcw, output, N*FCW_W, active FCW per channel, channel i at bits [i*FCW_W +: FCW_W].
REQ-015 The block SHALL have port pend, output, N, shadow-pending flag per channel.
REQ-016 The block SHALL have ports rd_en (input, 1) and rd_chn (input, IDX_W), the random-read request.
REQ-017 The block SHALL have ports rd_vld (output, 1), rd_err (output, 1), rd_fcw (output, FCW_W), rd_tofs (output, TOFS_W) and rd_nsym (output, NSYM_W), the read response.
REQ-018 The block SHALL have ports commit_cnt (output, 16, number of sync_in commits) and ovf (output, N, sticky overwrite flag).
REQ-019 The block SHALL have port ovf_clr, input, 1, clears all ovf bits.

Function
REQ-020 Each channel SHALL hold one shadow entry {fcw, tofs, nsym}, one active entry of the same fields, and a pend bit.
REQ-021 When c_valid[i]=1, the shadow entry of channel i SHALL load the write data at the next edge and pend[i] SHALL be set to 1.
REQ-022 When several c_valid bits are set in the same cycle, every selected channel SHALL load the same data.
REQ-023 When sync_in=1, every channel with pend=1 SHALL copy shadow to active and clear pend at the next edge; channels with pend=0 SHALL keep their active entry unchanged.
REQ-024 When c_valid[i] and sync_in occur in the same cycle, active SHALL take the old shadow (only if pend was 1), shadow SHALL take the new data, and pend[i] SHALL end at 1.
REQ-025 ctrl_fcw SHALL be driven directly from the active registers, so a change appears 1 cycle after the sync_in edge.
REQ-026 commit_cnt SHALL increment by 1 on every sync_in, whether or not any channel is pending, and SHALL wrap from 0xFFFF to 0.
REQ-027 rd_en SHALL produce a response with latency 1: rd_vld=1 one cycle later with the active entry of rd_chn.
REQ-028 If rd_chn >= N, the response SHALL have rd_err=1 and rd_fcw, rd_tofs and rd_nsym all 0.
REQ-029 When rd_en=0, rd_vld and rd_err SHALL be 0 on the next cycle and the rd data outputs SHALL hold their previous values.
REQ-030 A read in the same cycle as a commit SHALL return the pre-commit active value.

Reset
REQ-031 Assertion of rst SHALL asynchronously clear all shadow, active, pend, ovf, commit_cnt, rd_* outputs and ctrl_fcw to 0.
REQ-032 Reset asserted mid-operation SHALL discard all pending writes, so no commit occurs on the first sync_in after release unless a new write precedes it.
REQ-033 The block SHALL act on c_valid and sync_in from the first edge after rst deasserts.

Configuration
REQ-034 With macro PRACH_CTRL_BANK_OVF_EN defined, ovf[i] SHALL set when c_valid[i]=1 while pend[i]=1 and sync_in=0; the overwrite still occurs.
REQ-035 With PRACH_CTRL_BANK_OVF_EN defined, ovf_clr SHALL clear all bits at the next edge, and a simultaneous set SHALL win over the clear.
REQ-036 Without PRACH_CTRL_BANK_OVF_EN, ovf SHALL be constant 0, ovf_clr SHALL be ignored, and no ovf registers SHALL be built.

Structure
REQ-037 Package prach_pkg SHALL hold the default width constants and typedef prach_ctrl_t (packed struct fcw/tofs/nsym).
REQ-038 Per-channel shadow/active/pend logic SHALL be one sub-module, prach_ctrl_entry, generated N times; read mux, commit_cnt and ovf logic SHALL live in the top.

Verification
REQ-039 Write test: after reset, c_valid[5]=1 with fcw=0x1ABCD -> pend[5]=1 and ctrl_fcw ch5 still 0; sync_in -> ctrl_fcw ch5=0x1ABCD, pend[5]=0, commit_cnt=1.
REQ-040 Overwrite test (OVF_EN): write ch0 fcw=0x100 then fcw=0x200 with no sync -> ovf[0]=1; sync -> active fcw=0x200; ovf_clr -> ovf=0.
REQ-041 Simultaneous test: pend[3]=1 with shadow fcw=0x11; c_valid[3] fcw=0x22 together with sync_in -> active=0x11, shadow=0x22, pend[3]=1, ovf[3]=0.
REQ-042 Read test: rd_en with rd_chn=23 -> next cycle rd_vld=1 with the ch23 active entry; rd_chn=24 (N=24) -> rd_err=1 and data 0.
REQ-043 Wrap test: 65536 sync_in pulses -> commit_cnt=0; NUM_CC=2, NUM_ANT=4 build passes REQ-039 on ch7.
REQ-044 Reset test: rst mid-pending on ch2 -> after release, sync_in leaves ctrl_fcw ch2=0 and pend=0.
